// File: rtl/hvac_pkg.sv
// hvac_pkg: shared types and widened temperature compares for the zone scheduler
package hvac_pkg;
  localparam int TEMP_W = 12;
  typedef logic signed [TEMP_W-1:0] temp_t;
  typedef enum logic {HEAT, COOL} hvac_mode_e;
  typedef enum logic [1:0] {LOCKOUT, IDLE, RUN} sched_state_e;
  // int operands leave headroom so setpoint +/- offset never wraps
  function automatic logic temp_lt_ofs(input int a, input int b, input int ofs);
    return a < b - ofs;
  endfunction
  function automatic logic temp_gt_ofs(input int a, input int b, input int ofs);
    return a > b + ofs;
  endfunction
endpackage

// File: rtl/hvac_zone_scheduler_rr_pick.sv
// rr_pick: first set request at or after a start index, wrapping modulo N
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);
  logic [W-1:0] j;
  // scan farthest offset first so the nearest hit wins
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(start) + k) % N);
      if (req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/hvac_zone_scheduler.sv
// hvac_zone_scheduler: round-robin sharing of one heat/cool plant across zones
// with compressor minimum-on, minimum-off and maximum-run enforcement
module hvac_zone_scheduler
  import hvac_pkg::*;
#(
  parameter int NZONES  = 4,
  parameter int TW      = 12,
  parameter int HYST    = 5,
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 4,
  parameter int MAX_RUN = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NZONES*TW-1:0]      setpoint,
  input  logic [NZONES*TW-1:0]      temp,
  output logic                      heat,
  output logic                      cool,
  output logic [NZONES-1:0]         damper,
  output logic [$clog2(NZONES)-1:0] active_zone,
  output logic                      lockout,
  output logic [NZONES-1:0]         demand_heat,
  output logic [NZONES-1:0]         demand_cool
);
  localparam int ZW = $clog2(NZONES);
  localparam int RW = $clog2(MAX_RUN + 1);
  localparam int OW = $clog2(MIN_OFF) + 1;
  localparam logic [RW-1:0] RUN_MIN = RW'(MIN_ON - 1);
  localparam logic [RW-1:0] RUN_PRE = RW'(MAX_RUN - 1);
  localparam logic [RW-1:0] RUN_SAT = RW'(MAX_RUN);
  localparam logic [OW-1:0] OFF_LAST = OW'(MIN_OFF - 1);
  localparam logic [ZW-1:0] ZLAST = ZW'(NZONES - 1);

  logic signed [TW-1:0] t_a [NZONES];
  logic signed [TW-1:0] s_a [NZONES];
  sched_state_e state;
  hvac_mode_e mode;
  logic [RW-1:0] run_cnt;
  logic [OW-1:0] off_cnt;
  logic [ZW-1:0] last_zone, start, pick;
  logic [NZONES-1:0] req, req_other;
  logic found, sat, other, stop;

  always_comb begin
    for (int i = 0; i < NZONES; i++) begin
      t_a[i] = temp[i*TW +: TW];
      s_a[i] = setpoint[i*TW +: TW];
      demand_heat[i] = temp_lt_ofs(int'(t_a[i]), int'(s_a[i]), HYST);
      demand_cool[i] = temp_gt_ofs(int'(t_a[i]), int'(s_a[i]), HYST);
    end
  end

  always_comb begin
    req_other = req;
    req_other[active_zone] = 1'b0;
  end

  assign req = demand_heat | demand_cool;
  assign start = (last_zone == ZLAST) ? '0 : last_zone + 1'b1;
  assign other = |req_other;
  assign sat = (mode == HEAT) ? (t_a[active_zone] >= s_a[active_zone])
                              : (t_a[active_zone] <= s_a[active_zone]);
  // enable low stops immediately; otherwise honour min-on before satisfaction exit
  assign stop = !enable || (sat && run_cnt >= RUN_MIN) || (other && run_cnt >= RUN_PRE);
  assign lockout = state == LOCKOUT;

  rr_pick #(.N(NZONES)) u_pick (
    .req  (req),
    .start(start),
    .found(found),
    .idx  (pick)
  );

  // plant outputs follow the pre-edge state, so heat/cool and damper move together
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= LOCKOUT;
      mode        <= HEAT;
      run_cnt     <= '0;
      off_cnt     <= '0;
      last_zone   <= ZLAST;
      active_zone <= '0;
      heat        <= 1'b0;
      cool        <= 1'b0;
      damper      <= '0;
    end else begin
      heat   <= state == RUN && enable && mode == HEAT;
      cool   <= state == RUN && enable && mode == COOL;
      damper <= (state == RUN && enable) ? NZONES'(1) << active_zone : '0;
      case (state)
        LOCKOUT: begin
          off_cnt <= off_cnt + 1'b1;
          if (off_cnt == OFF_LAST) begin
            state   <= IDLE;
            off_cnt <= '0;
          end
        end
        IDLE:
          if (enable && found) begin
            state       <= RUN;
            active_zone <= pick;
            mode        <= demand_heat[pick] ? HEAT : COOL;
            run_cnt     <= '0;
          end
        RUN: begin
          run_cnt <= (run_cnt == RUN_SAT) ? run_cnt : run_cnt + 1'b1;
          if (stop) begin
            state     <= LOCKOUT;
            off_cnt   <= '0;
            last_zone <= active_zone;
          end
        end
        default: state <= LOCKOUT;
      endcase
    end
endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// tb_hvac_zone_scheduler: directed scoreboard bench for the zone scheduler
module tb_hvac_zone_scheduler;
  logic clk = 1'b0;
  logic reset, enable;
  logic signed [11:0] t [4];
  logic signed [11:0] s [4];
  logic [47:0] temp, setpoint;
  logic heat, cool, lockout;
  logic [3:0] damper, demand_heat, demand_cool;
  logic [1:0] active_zone;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb [$];
  int checks = 0;
  int errors = 0;
  int both_n = 0;

  assign temp = {t[3], t[2], t[1], t[0]};
  assign setpoint = {s[3], s[2], s[1], s[0]};

  always #5 clk = ~clk;
  always @(negedge clk) if (heat && cool) both_n++;

  hvac_zone_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .setpoint   (setpoint),
    .temp       (temp),
    .heat       (heat),
    .cool       (cool),
    .damper     (damper),
    .active_zone(active_zone),
    .lockout    (lockout),
    .demand_heat(demand_heat),
    .demand_cool(demand_cool)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0d", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wait_on(output int gap);
    gap = 0;
    while (!(heat | cool)) begin
      if (gap >= 300) begin
        gap = -1;
        return;
      end
      gap++;
      step(1);
    end
  endtask

  task automatic run_len(output int len);
    len = 0;
    while (heat | cool) begin
      if (len >= 300) begin
        len = -1;
        return;
      end
      len++;
      step(1);
    end
  endtask

  task automatic set_all(input logic signed [11:0] tv, input logic signed [11:0] sv);
    for (int i = 0; i < 4; i++) begin
      t[i] = tv;
      s[i] = sv;
    end
  endtask

  initial begin
    int n, hn, ln;
    reset = 1'b0;
    enable = 1'b1;
    set_all(180, 220);
    // reset state
    expect_v("rst_heat", 0); expect_v("rst_cool", 0); expect_v("rst_damper", 0);
    expect_v("rst_lockout", 1); expect_v("rst_zone", 0); expect_v("rst_dheat", 4'hF);
    expect_v("rst_dcool", 0);
    step(2);
    check_v(heat); check_v(cool); check_v(damper); check_v(lockout); check_v(active_zone);
    check_v(demand_heat); check_v(demand_cool);
    reset = 1'b1;
    expect_v("rel3_lockout", 1); expect_v("rel3_heat", 0);
    step(3);
    check_v(lockout); check_v(heat);
    expect_v("idle_lockout", 0); expect_v("idle_heat", 0);
    step(1);
    check_v(lockout); check_v(heat);
    expect_v("grant_heat", 0);
    step(1);
    check_v(heat);
    expect_v("first_heat", 1); expect_v("first_damper", 4'b0001); expect_v("first_cool", 0);
    step(1);
    check_v(heat); check_v(damper); check_v(cool);
    // minimum on: zone0 satisfied early, all others quiet
    set_all(220, 220);
    hn = 1;
    ln = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      hn += int'(heat);
      ln += int'(lockout);
    end
    expect_v("min_on_len", 8); expect_v("lockout_len", 4);
    check_v(hn); check_v(ln);
    // hysteresis and widened-compare boundaries
    enable = 1'b0;
    t[0] = 216; #1; expect_v("hy216_h", 0); expect_v("hy216_c", 0);
    check_v(demand_heat); check_v(demand_cool);
    t[0] = 214; #1; expect_v("hy214_h", 4'b0001); check_v(demand_heat);
    t[0] = 230; #1; expect_v("hy230_c", 4'b0001); expect_v("hy230_h", 0);
    check_v(demand_cool); check_v(demand_heat);
    t[0] = 225; #1; expect_v("hy225_h", 0); expect_v("hy225_c", 0);
    check_v(demand_heat); check_v(demand_cool);
    t[0] = 220; s[1] = -2048; t[1] = -2048; #1;
    expect_v("min_noheat", 0); check_v(demand_heat);
    s[1] = 2047; #1; expect_v("min_heat", 4'b0010); check_v(demand_heat);
    t[1] = 2047; #1; expect_v("max_nocool", 0); check_v(demand_cool);
    s[1] = -2048; #1; expect_v("max_cool", 4'b0010); check_v(demand_cool);
    set_all(220, 220);
    step(1);
    // round-robin preemption between zones 0 and 2
    reset = 1'b0;
    t[0] = 180;
    t[2] = 180;
    enable = 1'b1;
    step(1);
    reset = 1'b1;
    expect_v("rr0_gap", 6); expect_v("rr0_damper", 4'b0001); expect_v("rr0_zone", 0);
    expect_v("rr0_len", 32);
    wait_on(n); check_v(n); check_v(damper); check_v(active_zone);
    run_len(n); check_v(n);
    expect_v("rr2_gap", 5); expect_v("rr2_damper", 4'b0100); expect_v("rr2_zone", 2);
    expect_v("rr2_len", 32);
    wait_on(n); check_v(n); check_v(damper); check_v(active_zone);
    run_len(n); check_v(n);
    expect_v("rr3_gap", 5); expect_v("rr3_damper", 4'b0001);
    wait_on(n); check_v(n); check_v(damper);
    // enable-low override at run cycle 3
    step(1);
    enable = 1'b0;
    expect_v("ovr_heat", 0); expect_v("ovr_damper", 0); expect_v("ovr_lockout", 1);
    step(1);
    check_v(heat); check_v(damper); check_v(lockout);
    expect_v("ovr_idle_lockout", 0); expect_v("ovr_idle_heat", 0);
    step(6);
    check_v(lockout); check_v(heat);
    // async reset during a run
    enable = 1'b1;
    expect_v("ar_gap", 2); expect_v("ar_damper", 4'b0100);
    wait_on(n); check_v(n); check_v(damper);
    #2 reset = 1'b0;
    #1;
    expect_v("ar_heat", 0); expect_v("ar_damper0", 0); expect_v("ar_lockout", 1);
    expect_v("ar_zone", 0);
    check_v(heat); check_v(damper); check_v(lockout); check_v(active_zone);
    // changeover: zone1 cools, zone3 waits for heat
    set_all(220, 220);
    t[1] = 260;
    t[3] = 180;
    @(negedge clk);
    reset = 1'b1;
    expect_v("co1_gap", 6); expect_v("co1_cool", 1); expect_v("co1_heat", 0);
    expect_v("co1_damper", 4'b0010);
    wait_on(n); check_v(n); check_v(cool); check_v(heat); check_v(damper);
    t[1] = 220;
    expect_v("co1_len", 8);
    run_len(n); check_v(n);
    expect_v("co3_gap", 5); expect_v("co3_heat", 1); expect_v("co3_cool", 0);
    expect_v("co3_damper", 4'b1000); expect_v("both_high", 0);
    wait_on(n); check_v(n); check_v(heat); check_v(cool); check_v(damper);
    check_v(both_n);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
